// File: rtl/bus_rr_if.sv
// Host and device channels of the bus_rr interconnect. bus_rr takes the slave view;
// the surrounding system (hosts, devices, address map) takes the master view.
interface bus_rr_if #(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 8,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  localparam int BeW = DataWidth / 8;

  logic [NrHosts-1:0]                     host_req_i;
  logic [NrHosts-1:0]                     host_gnt_o;
  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i;
  logic [NrHosts-1:0]                     host_we_i;
  logic [NrHosts-1:0][BeW-1:0]            host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i;
  logic [NrHosts-1:0]                     host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o;
  logic [NrHosts-1:0]                     host_err_o;

  logic [NrDevices-1:0]                   device_req_o;
  logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o;
  logic [NrDevices-1:0]                   device_we_o;
  logic [NrDevices-1:0][BeW-1:0]          device_be_o;
  logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o;
  logic [NrDevices-1:0]                   device_rvalid_i;
  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i;
  logic [NrDevices-1:0]                   device_err_i;

  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base;
  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask;

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_rdata_i, device_err_i,
    output cfg_device_addr_base, cfg_device_addr_mask
  );

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_rdata_i, device_err_i,
    input  cfg_device_addr_base, cfg_device_addr_mask
  );
endinterface

// File: rtl/bus_rr.sv
// Multi-host shared bus: round-robin / fixed-priority arbiter, mask/base address decode,
// one-cycle registered response routing with an error response for unmapped addresses.
module bus_rr #(
  parameter int NrHosts       = 2,
  parameter int NrDevices     = 8,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter bit ArbRoundRobin = 1'b1
) (
  input logic      clk_i,
  input logic      rst_ni,
  bus_rr_if.slave  bus
);
  localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int BeW   = DataWidth / 8;

  typedef struct packed {
    logic             unmapped;
    logic [DevW-1:0]  dev;
    logic [HostW-1:0] host;
  } rsp_t;

  logic [HostW-1:0]        rr_last_q;
  logic [HostW-1:0]        winner;
  logic                    gnt_any;
  logic [NrDevices-1:0]    dev_match;
  logic [DevW-1:0]         dev_sel;
  logic                    mapped;
  logic                    rsp_pending_q;
  rsp_t                    rsp_q;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BeW-1:0]          win_be;
  logic [DataWidth-1:0]    win_wdata;

  // Scan starts one past the last winner (round-robin) or at host 0 (fixed priority).
  always_comb begin : arb
    int unsigned idx;
    idx     = 0;
    winner  = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NrHosts; i++) begin
      idx = ArbRoundRobin ? (32'(rr_last_q) + 32'd1 + 32'(i)) : 32'(i);
      if (idx >= 32'(NrHosts)) idx = idx - 32'(NrHosts);
      if (!gnt_any && rst_ni && bus.host_req_i[idx]) begin
        gnt_any = 1'b1;
        winner  = HostW'(idx);
      end
    end
  end

  always_comb begin
    bus.host_gnt_o = '0;
    for (int h = 0; h < NrHosts; h++)
      bus.host_gnt_o[h] = gnt_any && (winner == HostW'(h));
  end

  assign win_addr  = bus.host_addr_i[winner];
  assign win_we    = bus.host_we_i[winner];
  assign win_be    = bus.host_be_i[winner];
  assign win_wdata = bus.host_wdata_i[winner];

  for (genvar d = 0; d < NrDevices; d++) begin : g_dec
    assign dev_match[d] =
      (win_addr & bus.cfg_device_addr_mask[d]) == bus.cfg_device_addr_base[d];
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    dev_sel = '0;
    mapped  = 1'b0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (dev_match[d]) begin
        dev_sel = DevW'(d);
        mapped  = 1'b1;
      end
    end
  end

  always_comb begin
    bus.device_req_o   = '0;
    bus.device_addr_o  = '0;
    bus.device_we_o    = '0;
    bus.device_be_o    = '0;
    bus.device_wdata_o = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (gnt_any && mapped && (dev_sel == DevW'(d))) begin
        bus.device_req_o[d]   = 1'b1;
        bus.device_addr_o[d]  = win_addr;
        bus.device_we_o[d]    = win_we;
        bus.device_be_o[d]    = win_be;
        bus.device_wdata_o[d] = win_wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_q     <= HostW'(NrHosts - 1);
      rsp_pending_q <= 1'b0;
      rsp_q         <= '0;
    end else begin
      rsp_pending_q <= gnt_any;
      if (gnt_any) begin
        rr_last_q <= winner;
        rsp_q     <= '{unmapped: !mapped, dev: dev_sel, host: winner};
      end
    end
  end

  // Unmapped accesses answer locally with an error; otherwise forward the device's reply.
  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_rdata_o  = '0;
    bus.host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (rsp_pending_q && (rsp_q.host == HostW'(h))) begin
        if (rsp_q.unmapped) begin
          bus.host_rvalid_o[h] = 1'b1;
          bus.host_err_o[h]    = 1'b1;
        end else begin
          bus.host_rvalid_o[h] = bus.device_rvalid_i[rsp_q.dev];
          bus.host_rdata_o[h]  = bus.device_rdata_i[rsp_q.dev];
          bus.host_err_o[h]    = bus.device_err_i[rsp_q.dev];
        end
      end
    end
  end
endmodule

// File: doc/bus_rr.md
Name: bus_rr

Overview:
- Parametrised successor to the single-master-priority system bus.
- Connects NrHosts bus hosts (core data port, debug SBA, future DMA) to NrDevices memory-mapped devices over one shared request channel.
- Adds round-robin or fixed-priority arbitration, a registered response-routing pipeline (back-to-back grants) and an error response for unmapped addresses.
- Sits between ibex_top/dm_top host ports and the peripheral device ports in the demo system.

Parameters:
- NrHosts, 2, number of hosts (1..8).
- NrDevices, 8, number of devices (1..16).
- DataWidth, 32, data bus width in bits.
- AddressWidth, 32, address width in bits.
- ArbRoundRobin, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest host index wins.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- host_req_i  in  1 [NrHosts]  host request
- host_gnt_o  out  1 [NrHosts]  grant, same cycle as request
- host_addr_i  in  AddressWidth [NrHosts]  byte address
- host_we_i  in  1 [NrHosts]  write enable
- host_be_i  in  DataWidth/8 [NrHosts]  byte enables
- host_wdata_i  in  DataWidth [NrHosts]  write data
- host_rvalid_o  out  1 [NrHosts]  response valid
- host_rdata_o  out  DataWidth [NrHosts]  read data
- host_err_o  out  1 [NrHosts]  error, qualified by rvalid
- device_req_o  out  1 [NrDevices]  device request
- device_addr_o  out  AddressWidth [NrDevices]  address
- device_we_o  out  1 [NrDevices]  write enable
- device_be_o  out  DataWidth/8 [NrDevices]  byte enables
- device_wdata_o  out  DataWidth [NrDevices]  write data
- device_rvalid_i  in  1 [NrDevices]  device response valid
- device_rdata_i  in  DataWidth [NrDevices]  device read data
- device_err_i  in  1 [NrDevices]  device error, qualified by rvalid
- cfg_device_addr_base  in  AddressWidth [NrDevices]  device base address
- cfg_device_addr_mask  in  AddressWidth [NrDevices]  device address mask

Behaviour:
- Single clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset state: rr_last_q = NrHosts-1, rsp_pending_q = 0. All host_rvalid_o, host_err_o, host_gnt_o and device_req_o are 0 while in reset; rdata outputs are 0.
- Arbitration (combinational, each cycle): at most one host granted.
  - Round-robin: scan hosts starting at (rr_last_q+1) mod NrHosts; the first with req=1 wins.
  - Fixed priority: the lowest-index requesting host wins.
  - host_gnt_o[winner] = 1 in the same cycle; all other grants are 0.
  - rr_last_q <= winner only on a cycle with a grant; it holds otherwise.
- Decode: device d matches if (addr & mask[d]) == base[d].
  - If several devices match, the lowest index wins.
  - On a match, device_req_o[d] = 1 and addr/we/be/wdata of the winning host are forwarded to device d. All other device_req_o are 0. Non-selected device payload outputs are driven 0.
  - No match (unmapped): the grant is still given and no device_req is asserted.
- Response pipeline: every device responds exactly one cycle after its request.
  - On each grant, register rsp_pending_q = 1, rsp_host_q = winner, rsp_dev_q = d, rsp_unmapped_q = (no match).
  - Next cycle, when rsp_pending_q:
    - host_rvalid_o[rsp_host_q] = rsp_unmapped_q ? 1 : device_rvalid_i[rsp_dev_q].
    - host_rdata_o[rsp_host_q] = unmapped ? 0 : device_rdata_i[rsp_dev_q].
    - host_err_o[rsp_host_q] = unmapped ? 1 : device_err_i[rsp_dev_q].
  - Non-addressed hosts receive rvalid = 0, err = 0, rdata = 0.
  - Device rvalid with no pending entry for that device is dropped.
- Back-to-back: a grant in cycle N+1 may coincide with the response for cycle N. Sustained throughput is 1 transaction/cycle. rsp_pending_q = 0 on a cycle without a grant.
- Boundaries:
  - NrHosts = 1: the arbiter degenerates to pass-through.
  - Pointer wraps from NrHosts-1 to 0.
  - A host holding req stays granted every cycle it wins. Under round-robin, a continuous requester yields to any other requester on the next cycle.
- Reset mid-transaction: the pending response is discarded and no rvalid is issued after reset release; the pointer returns to NrHosts-1.

Test Plan:
- Single host 0 reads 0x00100010 (RAM base 0x00100000, mask 0xFFFF0000); device returns 0xDEADBEEF -> gnt[0] same cycle, device_req[Ram] = 1, next cycle rvalid[0] = 1, rdata = 0xDEADBEEF, err = 0.
- Hosts 0 and 1 both request continuously for 6 cycles, ArbRoundRobin = 1 -> grant sequence 0,1,0,1,0,1, each response routed to the correct host one cycle later. With ArbRoundRobin = 0 -> host 0 granted all 6 cycles.
- Host 1 accesses unmapped 0x40000000 -> gnt[1] = 1, no device_req, next cycle rvalid[1] = 1, err[1] = 1, rdata = 0.
- Back-to-back: host 0 writes GPIO 0x80000000 then reads UART 0x80001000 in consecutive cycles -> two device requests in consecutive cycles, two rvalids in consecutive cycles, correct rdata per transaction.
- Device Timer returns err = 1 -> host err asserted with rvalid for exactly 1 cycle.
- Assert rst_ni low in the cycle after a grant -> no rvalid after release; the first grant after release goes to host 0 when both hosts request.
